mem_access_unit: RTL and testbench

//  MEM-stage responder for the load/store control bundle produced in ID (read/write/sign-ext flags,

---
 rtl/mem_access_unit_if.sv | 48 ++++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Bundle for the MEM-stage load/store unit. Carries the ID
//               control bundle (flags, byte select, address, store data),
//               the handshaked data-RAM port and the results back to the
//               pipeline (load data/valid, stall, bus error).
//               slave  : view of mem_access_unit
//               master : view of the surrounding pipeline / RAM model
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
  // Pipeline request bundle
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic        mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  // Data-RAM port
  logic [31:0] ram_rdata;
  logic        ram_ready;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  // Results to the pipeline
  logic [31:0] load_data;
  logic        load_valid;
  logic        stall_req;
  logic        bus_err;

  modport slave (
    input  mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_sel,
    input  mem_addr, mem_write_data, ram_rdata, ram_ready,
    output ram_en, ram_we, ram_sel, ram_addr, ram_wdata,
    output load_data, load_valid, stall_req, bus_err
  );

  modport master (
    output mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_sel,
    output mem_addr, mem_write_data, ram_rdata, ram_ready,
    input  ram_en, ram_we, ram_sel, ram_addr, ram_wdata,
    input  load_data, load_valid, stall_req, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store responder. Latches the request, drives
//               a handshaked data-RAM access with shifted lane enables and
//               replicated store data, extracts/extends the load result and
//               stalls the pipeline until the access completes.
//               Little-endian byte order. FSM: IDLE -> ACCESS -> DONE -> IDLE.
// Ports       : clk, rst_n (async, active low), bus (mem_access_unit_if.slave)
// Parameters  : TIMEOUT_CYCLES - ACCESS cycles without ram_ready before the
//               access is aborted with bus_err; 0 waits forever.
// Config      : MEM_ALIGN_CHECK_EN - when defined, misaligned half/word
//               requests skip the RAM access and report bus_err.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_access_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int unsigned      CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [31:0]      r_addr;
  logic [3:0]       r_sel;
  logic [31:0]      r_data;
  logic             r_we;
  logic             r_sign;
  logic             r_load;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_load_data;

  logic        w_req;
  logic        w_idle;
  logic        w_access;
  logic        w_done;
  logic [1:0]  w_off;
  logic        w_word;
  logic        w_half;
  logic [3:0]  w_lane_sel;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_load_ext;

  assign w_req    = (bus.mem_read_flag | bus.mem_write_flag) & (|bus.mem_sel);
  assign w_idle   = (r_state == S_IDLE);
  assign w_access = (r_state == S_ACCESS);
  assign w_done   = (r_state == S_DONE);

  // Access size decoded from the latched select; non-canonical patterns
  // fall back to the widest lane they touch.
  assign w_off      = r_addr[1:0];
  assign w_word     = r_sel[3] | r_sel[2];
  assign w_half     = ~w_word & r_sel[1];
  assign w_lane_sel = r_sel << w_off;

  assign w_wdata = w_word ? r_data :
                   w_half ? {2{r_data[15:0]}} : {4{r_data[7:0]}};

  assign w_shift    = bus.ram_rdata >> {w_off, 3'b000};
  assign w_load_ext = w_word ? w_shift :
                      w_half ? {{16{r_sign & w_shift[15]}}, w_shift[15:0]} :
                               {{24{r_sign & w_shift[7]}},  w_shift[7:0]};

`ifdef MEM_ALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = ((bus.mem_sel == 4'b1111) && (bus.mem_addr[1:0] != 2'b00)) ||
                      ((bus.mem_sel == 4'b0011) && bus.mem_addr[0]);
`endif

  // RAM port is only live in ACCESS so it drops immediately on reset.
  assign bus.ram_en    = w_access;
  assign bus.ram_we    = w_access & r_we;
  assign bus.ram_sel   = w_access ? w_lane_sel : 4'b0000;
  assign bus.ram_addr  = w_access ? {r_addr[31:2], 2'b00} : 32'd0;
  assign bus.ram_wdata = w_access ? w_wdata : 32'd0;

  // The IDLE term is combinational on the incoming request; rst_n gates it
  // so the stall is released while reset is held.
  assign bus.stall_req  = rst_n & ((w_idle & w_req) | w_access);
  assign bus.load_data  = r_load_data;
  assign bus.load_valid = w_done & r_load & ~r_err;
  assign bus.bus_err    = w_done & r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= 32'd0;
      r_sel       <= 4'd0;
      r_data      <= 32'd0;
      r_we        <= 1'b0;
      r_sign      <= 1'b0;
      r_load      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_load_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_err <= 1'b0;
          if (w_req) begin
            r_addr  <= bus.mem_addr;
            r_sel   <= bus.mem_sel;
            r_data  <= bus.mem_write_data;
            r_we    <= bus.mem_write_flag;
            r_sign  <= bus.mem_sign_ext_flag;
            r_load  <= bus.mem_read_flag & ~bus.mem_write_flag;
`ifdef MEM_ALIGN_CHECK_EN
            if (w_misalign) begin
              r_err       <= 1'b1;
              r_load_data <= 32'd0;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_ACCESS;
            end
`else
            r_state <= S_ACCESS;
`endif
          end
        end
        S_ACCESS: begin
          if (bus.ram_ready) begin
            if (r_load) r_load_data <= w_load_ext;
            r_state <= S_DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == C_LAST)) begin
            r_err       <= 1'b1;
            r_load_data <= 32'd0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Directed cases for
//               aligned/unaligned loads and stores, timeout and async reset,
//               then randomized transactions checked against a byte-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_ld   = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [3:0] sel);
    case (sel)
      4'b1111: return 4;
      4'b0011: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] m_lanes(input logic [3:0] sel, input int off);
    int s;
    s = int'(sel) << off;
    return 32'(s & 15);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input int n);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input int off,
                                         input int n, input bit sx);
    longint unsigned v, m;
    v = {32'd0, rd} >> (8*off);
    m = (64'd1 << (8*n)) - 64'd1;
    v = v & m;
    if (sx && n < 4 && (((v >> (8*n-1)) & 64'd1) != 0)) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic clear_req();
    bus.mem_read_flag     = 1'b0;
    bus.mem_write_flag    = 1'b0;
    bus.mem_sign_ext_flag = 1'b0;
    bus.mem_sel           = 4'b0000;
  endtask

  // One transaction; delay = ACCESS cycle index in which ram_ready rises
  // (values >= TO never answer).
  task automatic txn(input bit rd, input bit wr, input bit sx, input logic [3:0] sel,
                     input logic [31:0] addr, input logic [31:0] d,
                     input logic [31:0] rdata, input int delay);
    bit req, is_load, tmo;
    int n, off;
    req     = (rd || wr) && (sel != 4'b0000);
    is_load = rd && !wr;
    n       = nbytes(sel);
    off     = int'(addr[1:0]);

    @(negedge clk);
    bus.mem_read_flag     = rd;
    bus.mem_write_flag    = wr;
    bus.mem_sign_ext_flag = sx;
    bus.mem_sel           = sel;
    bus.mem_addr          = addr;
    bus.mem_write_data    = d;
    bus.ram_ready         = 1'($urandom_range(0, 1));  // ignored outside ACCESS
    bus.ram_rdata         = $urandom();
    #1;
    check("idle_stall", bus.stall_req, req);
    check("idle_ram_en", bus.ram_en, 0);

    @(posedge clk); #1;
    clear_req();
    bus.mem_addr       = $urandom();
    bus.mem_write_data = $urandom();
    bus.ram_ready      = 1'b0;
    if (!req) begin
      check("noreq_stall", bus.stall_req, 0);
      check("noreq_ram_en", bus.ram_en, 0);
      check("noreq_ld", bus.load_data, exp_ld);
      return;
    end

`ifdef MEM_ALIGN_CHECK_EN
    if ((n == 2 && addr[0]) || (n == 4 && off != 0)) begin
      exp_ld = 32'd0;
      check("mis_ram_en", bus.ram_en, 0);
      check("mis_bus_err", bus.bus_err, 1);
      check("mis_valid", bus.load_valid, 0);
      check("mis_ld", bus.load_data, 32'd0);
      check("mis_stall", bus.stall_req, 0);
      @(posedge clk); #1;
      check("mis_err_pulse", bus.bus_err, 0);
      return;
    end
`endif

    tmo = (delay >= TO);
    for (int c = 0; c < TO; c++) begin
      check("acc_ram_en", bus.ram_en, 1);
      check("acc_ram_we", bus.ram_we, wr);
      check("acc_ram_sel", bus.ram_sel, m_lanes(sel, off));
      check("acc_ram_addr", bus.ram_addr, {addr[31:2], 2'b00});
      check("acc_ram_wdata", bus.ram_wdata, m_wdata(d, n));
      check("acc_stall", bus.stall_req, 1);
      check("acc_valid", bus.load_valid, 0);
      if (c == delay) begin
        bus.ram_ready = 1'b1;
        bus.ram_rdata = rdata;
      end else begin
        bus.ram_ready = 1'b0;
        bus.ram_rdata = $urandom();
      end
      @(posedge clk); #1;
      if (c == delay) break;
    end
    bus.ram_ready = 1'b0;

    if (tmo) exp_ld = 32'd0;
    else if (is_load) exp_ld = m_load(rdata, off, n, sx);
    check("done_stall", bus.stall_req, 0);
    check("done_ram_en", bus.ram_en, 0);
    check("done_bus_err", bus.bus_err, tmo);
    check("done_valid", bus.load_valid, is_load && !tmo);
    check("done_ld", bus.load_data, exp_ld);

    @(posedge clk); #1;
    check("post_valid", bus.load_valid, 0);
    check("post_bus_err", bus.bus_err, 0);
    check("post_stall", bus.stall_req, 0);
    check("post_ld", bus.load_data, exp_ld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rd, wr;
    logic [3:0] sel;
    int pick;

    // Request held high during reset: every output must stay 0.
    bus.mem_read_flag     = 1'b1;
    bus.mem_write_flag    = 1'b0;
    bus.mem_sign_ext_flag = 1'b0;
    bus.mem_sel           = 4'b1111;
    bus.mem_addr          = 32'h0000_0100;
    bus.mem_write_data    = 32'd0;
    bus.ram_rdata         = 32'd0;
    bus.ram_ready         = 1'b0;
    #12;
    check("rst_stall", bus.stall_req, 0);
    check("rst_ram_en", bus.ram_en, 0);
    check("rst_ram_sel", bus.ram_sel, 0);
    check("rst_valid", bus.load_valid, 0);
    check("rst_bus_err", bus.bus_err, 0);
    check("rst_ld", bus.load_data, 0);
    clear_req();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    txn(1, 0, 0, 4'b1111, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0);  // lw
    txn(1, 0, 1, 4'b0001, 32'h0000_0103, 32'd0, 32'h8011_2233, 0);  // lb
    check("lb_value", exp_ld, 32'hFFFF_FF80);
    txn(1, 0, 0, 4'b0001, 32'h0000_0103, 32'd0, 32'h8011_2233, 1);  // lbu
    check("lbu_value", exp_ld, 32'h0000_0080);
    txn(0, 1, 0, 4'b0011, 32'h0000_0202, 32'h0000_ABCD, 32'd0, 2);  // sh
    txn(1, 0, 0, 4'b1111, 32'h0000_0104, 32'd0, 32'h1234_5678, 99); // timeout
    txn(1, 1, 1, 4'b0011, 32'h0000_0300, 32'h0000_5555, 32'd0, 0);  // both -> store
    txn(1, 0, 1, 4'b0011, 32'h0000_0302, 32'd0, 32'hF00D_0000, 3);  // lh, last cycle
    txn(1, 0, 0, 4'b0000, 32'h0000_0400, 32'd0, 32'd0, 0);          // no lanes
`ifdef MEM_ALIGN_CHECK_EN
    txn(1, 0, 0, 4'b1111, 32'h0000_0101, 32'd0, 32'hAAAA_AAAA, 0);
`endif

    // Reset in the middle of an ACCESS with the request still asserted
    @(negedge clk);
    bus.mem_read_flag = 1'b1;
    bus.mem_sel       = 4'b1111;
    bus.mem_addr      = 32'h0000_0500;
    @(posedge clk); #1;
    check("mid_ram_en", bus.ram_en, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ram_en", bus.ram_en, 0);
    check("mid_rst_stall", bus.stall_req, 0);
    check("mid_rst_ld", bus.load_data, 0);
    exp_ld = 32'd0;
    @(negedge clk);
    clear_req();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst_stall", bus.stall_req, 0);
    check("after_rst_ram_en", bus.ram_en, 0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      pick = int'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0: sel = 4'b0001;
        1: sel = 4'b0011;
        2: sel = 4'b1111;
        default: sel = (pick == 0) ? 4'b0000 : 4'b0001;
      endcase
      rd = (pick < 6) || (pick == 9);
      wr = (pick >= 5);
      txn(rd, wr, 1'($urandom_range(0, 1)), sel, $urandom(), $urandom(), $urandom(),
          int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
